// File: rtl/clock_set_controller.sv
// Time/date setting controller: freezes the clock core, edits a snapshot field by field and
// commits it with a one-cycle load pulse. Optional macro CLK_SET_BLINK_EN builds the field blinker.
module clock_set_controller #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned YEAR_MIN  = 2000,
  parameter int unsigned YEAR_MAX  = 2099,
  parameter int unsigned TIMEOUT_S = 30
`ifdef CLK_SET_BLINK_EN
  ,
  parameter int unsigned BLINK_HZ  = 2
`endif
) (
  input  logic        built_in_clk,
  input  logic        glob_rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [5:0]  cur_sec,
  input  logic [5:0]  cur_min,
  input  logic [4:0]  cur_hour,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [13:0] cur_year,
  output logic        run_en,
  output logic        load,
  output logic [5:0]  set_sec,
  output logic [5:0]  set_min,
  output logic [4:0]  set_hour,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [13:0] set_year,
  output logic [5:0]  edit_field,
  output logic        blink
);

  localparam logic [13:0] YMin     = 14'(YEAR_MIN);
  localparam logic [13:0] YMax     = 14'(YEAR_MAX);
  localparam int unsigned TmoLast  = TIMEOUT_S * CLK_FREQ - 1;
  localparam logic [5:0]  FldYear  = 6'b100000;

  typedef enum logic [1:0] {StRun, StCapture, StEdit, StCommit} state_e;

  state_e      state;
  logic [31:0] tmo_cnt;
  logic        btn_mode_q, btn_next_q, btn_up_q, btn_down_q;
  logic        mode_edge, next_edge, up_edge, down_edge, any_edge;
  logic [4:0]  dim;

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    logic [4:0] d;
    d = 5'd31;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Range-aware step; a value above hi (stale day after a month edit) steps down to hi.
  function automatic logic [13:0] step_field(input logic [13:0] v, input logic [13:0] lo,
                                             input logic [13:0] hi, input logic up);
    logic [13:0] r;
    if (up) r = (v >= hi) ? lo : v + 14'd1;
    else if (v <= lo) r = hi;
    else if (v > hi) r = hi;
    else r = v - 14'd1;
    return r;
  endfunction

  always_ff @(posedge built_in_clk or posedge glob_rst) begin
    if (glob_rst) begin
      btn_mode_q <= 1'b0;
      btn_next_q <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_next_q <= btn_next;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
    end
  end

  always_comb begin
    mode_edge = btn_mode & ~btn_mode_q;
    next_edge = btn_next & ~btn_next_q;
    up_edge   = btn_up & ~btn_up_q;
    down_edge = btn_down & ~btn_down_q;
    any_edge  = mode_edge | next_edge | up_edge | down_edge;
    dim       = days_in_month(set_month, set_year);
  end

  always_ff @(posedge built_in_clk or posedge glob_rst) begin
    if (glob_rst) begin
      state      <= StRun;
      run_en     <= 1'b1;
      load       <= 1'b0;
      set_sec    <= 6'd0;
      set_min    <= 6'd0;
      set_hour   <= 5'd0;
      set_day    <= 5'd1;
      set_month  <= 4'd1;
      set_year   <= YMin;
      edit_field <= 6'd0;
      tmo_cnt    <= 32'd0;
    end else begin
      load <= 1'b0;
      unique case (state)
        StRun: begin
          tmo_cnt <= 32'd0;
          if (mode_edge) begin
            state      <= StCapture;
            run_en     <= 1'b0;
            edit_field <= FldYear;
          end
        end
        StCapture: begin
          set_sec    <= cur_sec;
          set_min    <= cur_min;
          set_hour   <= cur_hour;
          set_day    <= cur_day;
          set_month  <= cur_month;
          set_year   <= cur_year;
          edit_field <= FldYear;
          tmo_cnt    <= 32'd0;
          state      <= StEdit;
        end
        StEdit: begin
          if (any_edge) tmo_cnt <= 32'd0;
          if (mode_edge) begin
            state <= StCommit;
          end else if (next_edge) begin
            edit_field <= {edit_field[0], edit_field[5:1]};
          end else if (up_edge ^ down_edge) begin
            unique case (edit_field)
              6'b000001: set_sec   <= 6'(step_field({8'd0, set_sec}, 14'd0, 14'd59, up_edge));
              6'b000010: set_min   <= 6'(step_field({8'd0, set_min}, 14'd0, 14'd59, up_edge));
              6'b000100: set_hour  <= 5'(step_field({9'd0, set_hour}, 14'd0, 14'd23, up_edge));
              6'b001000: set_day   <= 5'(step_field({9'd0, set_day}, 14'd1, {9'd0, dim},
                                                    up_edge));
              6'b010000: set_month <= 4'(step_field({10'd0, set_month}, 14'd1, 14'd12, up_edge));
              6'b100000: set_year  <= step_field(set_year, YMin, YMax, up_edge);
              default: ;
            endcase
          end else if (!any_edge) begin
            if (tmo_cnt == TmoLast) begin
              // Abandon: core resumes with its own time, no load.
              state      <= StRun;
              run_en     <= 1'b1;
              edit_field <= 6'd0;
              tmo_cnt    <= 32'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end
        end
        StCommit: begin
          if (set_day > dim) set_day <= dim;
          load       <= 1'b1;
          run_en     <= 1'b1;
          edit_field <= 6'd0;
          state      <= StRun;
        end
        default: state <= StRun;
      endcase
    end
  end

`ifdef CLK_SET_BLINK_EN
  localparam int unsigned BlinkHalf = CLK_FREQ / (2 * BLINK_HZ);

  logic [31:0] blink_cnt;

  // An up/down edge restarts the half-period with the field visible.
  always_ff @(posedge built_in_clk or posedge glob_rst) begin
    if (glob_rst) begin
      blink     <= 1'b0;
      blink_cnt <= 32'd0;
    end else if (state != StEdit) begin
      blink     <= 1'b0;
      blink_cnt <= 32'd0;
    end else if (up_edge || down_edge) begin
      blink     <= 1'b0;
      blink_cnt <= 32'd0;
    end else if (blink_cnt >= BlinkHalf - 1) begin
      blink     <= ~blink;
      blink_cnt <= 32'd0;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule
